// File: rtl/prod_accum_19s.sv
// Block accumulator for signed multiplier products. Each accepted add saturates
// to OUT_W bits, and one sum_valid pulse presents the block total.
module prod_accum_19s #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] blk_len,
  input  logic             prod_valid,
  input  logic [IN_W-1:0]  product,
  output logic             busy,
  output logic             sum_valid,
  output logic [OUT_W-1:0] sum_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [OUT_W-1:0] ACC_ZERO = {OUT_W{1'b0}};

  // Saturating add. The MSB of the result flags a clamp, and the low OUT_W bits
  // hold the clamped sum. The extra guard bit makes overflow visible as a
  // disagreement between the top two bits.
  function automatic logic [OUT_W:0] sat_add(input logic [OUT_W-1:0] a,
                                             input logic [IN_W-1:0]  p);
    logic [OUT_W:0] wide;
    logic [OUT_W:0] res;
    wide = {a[OUT_W-1], a} + {{(OUT_W+1-IN_W){p[IN_W-1]}}, p};
    if (wide[OUT_W] != wide[OUT_W-1]) begin
      if (wide[OUT_W]) begin
        res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      res = {1'b0, wide[OUT_W-1:0]};
    end
    return res;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [OUT_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic [OUT_W:0]   add_s;
  logic             start_acc_s;
  logic             done_entry_s;
  logic             busy_r, valid_r, ovfo_r;
  logic [OUT_W-1:0] sum_r;

  // Next-state and accumulator datapath decode
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    start_acc_s = 1'b0;
    add_s       = sat_add(acc_r, product);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          acc_nxt_s   = ACC_ZERO;
          ovf_nxt_s   = 1'b0;
          cnt_nxt_s   = blk_len;
          if (blk_len == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (prod_valid) begin
          acc_nxt_s = add_s[OUT_W-1:0];
          ovf_nxt_s = ovf_r | add_s[OUT_W];
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // DONE is always left after one cycle, so any transition into DONE is an entry
  assign done_entry_s = (state_nxt_s == ST_DONE);

  // FSM state and accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      acc_r   <= ACC_ZERO;
      cnt_r   <= CNT_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Registered outputs. The total and the sticky flag are captured on DONE
  // entry, so they are already final during the sum_valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      sum_r   <= ACC_ZERO;
      ovfo_r  <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s != ST_IDLE);
      valid_r <= done_entry_s;
      if (done_entry_s) begin
        sum_r  <= acc_nxt_s;
        ovfo_r <= ovf_nxt_s;
      end else if (start_acc_s) begin
        sum_r  <= ACC_ZERO;
        ovfo_r <= 1'b0;
      end else begin
        sum_r  <= sum_r;
        ovfo_r <= ovfo_r;
      end
    end
  end

  assign busy      = busy_r;
  assign sum_valid = valid_r;
  assign sum_out   = sum_r;
  assign overflow  = ovfo_r;

endmodule

// File: tb/tb_prod_accum_19s.sv
// Self-checking bench for prod_accum_19s: directed blocks plus randomized blocks
// compared against a plain-arithmetic saturating block-sum model.
module tb_prod_accum_19s;

  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  blk_len;
  logic        prod_valid;
  logic [18:0] product;
  logic        busy;
  logic        sum_valid;
  logic [23:0] sum_out;
  logic        overflow;

  int n_vec;
  int n_err;
  int prod_q[$];
  int gap_q[$];

  prod_accum_19s dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .blk_len   (blk_len),
    .prod_valid(prod_valid),
    .product   (product),
    .busy      (busy),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: running sum clamped to the 24-bit signed range after every add
  function automatic void ref_model(output longint s, output bit o);
    s = 0;
    o = 1'b0;
    foreach (prod_q[i]) begin
      s = s + longint'(prod_q[i]);
      if (s > MAXV) begin
        s = MAXV;
        o = 1'b1;
      end else if (s < MINV) begin
        s = MINV;
        o = 1'b1;
      end
    end
  endfunction

  function automatic int rand_prod(input int mode);
    int v;
    v = int'($urandom_range(0, 262143));
    case (mode)
      1:       return v;
      2:       return -v - 1;
      default: return int'($urandom_range(0, 1)) == 1 ? v : -v - 1;
    endcase
  endfunction

  task automatic run_block(input string nm, input bit mid_start);
    longint exp_sum;
    bit     exp_ovf;
    int     len;
    len = prod_q.size();
    ref_model(exp_sum, exp_ovf);
    @(negedge clk);
    start      = 1'b1;
    blk_len    = 8'(len);
    prod_valid = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    blk_len = 8'($urandom);
    if (len > 0) begin
      check_val({nm, "_armed_busy"}, longint'(busy), 1);
      check_val({nm, "_armed_valid"}, longint'(sum_valid), 0);
    end
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        if (mid_start && i == 1 && g == 0) begin
          start   = 1'b1;
          blk_len = 8'd1;
        end
        @(negedge clk);
        start = 1'b0;
        check_val({nm, "_gap_valid"}, longint'(sum_valid), 0);
      end
      prod_valid = 1'b1;
      product    = 19'(prod_q[i]);
      @(negedge clk);
      prod_valid = 1'b0;
      if (i != len - 1) begin
        check_val({nm, "_early_valid"}, longint'(sum_valid), 0);
      end
    end
    check_val({nm, "_sum_valid"}, longint'(sum_valid), 1);
    check_val({nm, "_sum_out"}, longint'($signed(sum_out)), exp_sum);
    check_val({nm, "_overflow"}, longint'(overflow), longint'(exp_ovf));
    check_val({nm, "_busy_done"}, longint'(busy), 1);
    // Stray products in DONE and IDLE must be dropped
    prod_valid = 1'b1;
    product    = 19'($urandom);
    @(negedge clk);
    @(negedge clk);
    prod_valid = 1'b0;
    check_val({nm, "_pulse_end"}, longint'(sum_valid), 0);
    check_val({nm, "_idle_busy"}, longint'(busy), 0);
    check_val({nm, "_hold_sum"}, longint'($signed(sum_out)), exp_sum);
    check_val({nm, "_hold_ovf"}, longint'(overflow), longint'(exp_ovf));
  endtask

  task automatic set_block(input int n, input int val, input int gap);
    prod_q = {};
    gap_q  = {};
    for (int i = 0; i < n; i++) begin
      prod_q.push_back(val);
      gap_q.push_back(gap);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    blk_len    = 8'd0;
    prod_valid = 1'b0;
    product    = 19'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_valid", longint'(sum_valid), 0);
    check_val("rst_sum", longint'($signed(sum_out)), 0);
    check_val("rst_ovf", longint'(overflow), 0);

    prod_q = '{116025, -1000, 5};
    gap_q  = '{0, 0, 0};
    run_block("basic", 1'b0);

    prod_q = '{100, -300};
    gap_q  = '{0, 2};
    run_block("gaps", 1'b0);

    set_block(64, 131072, 0);
    run_block("possat", 1'b0);

    set_block(65, -130048, 0);
    prod_q.push_back(130048);
    gap_q.push_back(0);
    run_block("negsat", 1'b0);

    prod_q = {};
    gap_q  = {};
    run_block("empty", 1'b0);

    prod_q = '{7, 8};
    gap_q  = '{0, 2};
    run_block("midstart", 1'b1);

    // Reset held two cycles in the middle of a block
    @(negedge clk);
    start   = 1'b1;
    blk_len = 8'd5;
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    product    = 19'd1000;
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("midrst_busy", longint'(busy), 0);
    check_val("midrst_valid", longint'(sum_valid), 0);
    check_val("midrst_sum", longint'($signed(sum_out)), 0);
    check_val("midrst_ovf", longint'(overflow), 0);
    // Products after reset must not complete the discarded block
    prod_valid = 1'b1;
    product    = 19'd3;
    repeat (4) @(negedge clk);
    prod_valid = 1'b0;
    check_val("midrst_idle_valid", longint'(sum_valid), 0);
    check_val("midrst_idle_busy", longint'(busy), 0);

    prod_q = '{-42, 42, 9};
    gap_q  = '{1, 0, 3};
    run_block("postrst", 1'b0);

    for (int b = 0; b < 30; b++) begin
      int n;
      int mode;
      mode   = int'($urandom_range(0, 2));
      n      = (b % 3 == 0) ? int'($urandom_range(30, 120)) : int'($urandom_range(0, 12));
      prod_q = {};
      gap_q  = {};
      for (int i = 0; i < n; i++) begin
        prod_q.push_back(rand_prod(mode));
        gap_q.push_back(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 2)) : 0);
      end
      run_block("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
